game_session_controller: RTL

Parametrised successor to the single-life gameplay controller. It sequences one logged-in player through repeated games and drives the timer/score reconfigure and enable pulses. It also tracks score, level, remaining lives and the session-best score, and issues the logout pulse to authentication. It sits between the authentication block, the sequence checker and the timer/score display, and feeds the score checker at end of game.

---
 rtl/game_pkg.sv | 22 ++
 rtl/sat_counter.sv | 28 ++
 rtl/game_session_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, default constants and saturating increment
package game_pkg;

    typedef enum logic [2:0] {
        INACTIVE  = 3'd0,
        RECONFIG  = 3'd1,
        WAITSTART = 3'd2,
        PLAY      = 3'd3,
        GAMEOVER  = 3'd4,
        DELAY     = 3'd5
    } state_t;

    localparam int DEF_MAX_LEVEL    = 5;
    localparam int DEF_LIVES        = 3;
    localparam int DEF_LOGOUT_DELAY = 16;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter with clear, load and increment
module sat_counter
    import game_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    // Clear wins over load, load wins over increment.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= WIDTH'(sat_inc(32'(count), 32'(MAX)));
        end
    end

endmodule

// File: rtl/game_session_controller.sv
// rtl/game_session_controller.sv - per-session game sequencer with score, level, lives and best score
module game_session_controller
    import game_pkg::*;
#(
    parameter int SCORE_W      = 7,
    parameter int LEVEL_W      = 4,
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int LIVES        = DEF_LIVES,
    parameter int LEVEL_STEP   = 1,
    parameter int LOGOUT_DELAY = DEF_LOGOUT_DELAY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               passed,
    input  logic               correct,
    input  logic               incorrect,
    input  logic               game_b,
    input  logic               psub_b_in,
    input  logic               seq_b_in,
    input  logic               timeout,
    output logic               ts_reconfig,
    output logic               ts_enable,
    output logic               psub_b_out,
    output logic               seq_b_out,
    output logic               miss,
    output logic               dead,
    output logic               checkscore,
    output logic               logout,
    output logic [LEVEL_W-1:0] currentlevel,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives_left,
    output logic [SCORE_W-1:0] best_score
);

    localparam int DLY_W     = $clog2(LOGOUT_DELAY + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       streak;
    logic             logout_prev;

    logic reconf, start, hit, miss_d, dead_d, over_d, logout_d, level_up;

    assign level_up = hit && (streak == 4'(LEVEL_STEP - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= INACTIVE;
        else      state_q <= state_d;
    end

    // Next-state and per-cycle event decode; timeout beats incorrect beats correct.
    always_comb begin
        state_d  = state_q;
        reconf   = 1'b0;
        start    = 1'b0;
        hit      = 1'b0;
        miss_d   = 1'b0;
        dead_d   = 1'b0;
        over_d   = 1'b0;
        logout_d = 1'b0;
        case (state_q)
            INACTIVE: begin
                // The previous-cycle logout check masks a login level still held high.
                if (passed && !logout_prev) begin
                    state_d = RECONFIG;
                    reconf  = 1'b1;
                end
            end
            RECONFIG: state_d = WAITSTART;
            WAITSTART: begin
                if (game_b) begin
                    state_d = PLAY;
                    start   = 1'b1;
                end else if (psub_b_in) begin
                    state_d  = DELAY;
                    logout_d = 1'b1;
                end
            end
            PLAY: begin
                if (timeout) begin
                    state_d = GAMEOVER;
                    over_d  = 1'b1;
                end else if (incorrect) begin
                    if (lives_left > 4'd1) begin
                        miss_d = 1'b1;
                    end else begin
                        dead_d  = 1'b1;
                        over_d  = 1'b1;
                        state_d = GAMEOVER;
                    end
                end else if (correct) begin
                    hit = 1'b1;
                end
            end
            GAMEOVER: begin
                if (game_b) begin
                    state_d = RECONFIG;
                    reconf  = 1'b1;
                end else if (psub_b_in) begin
                    state_d  = DELAY;
                    logout_d = 1'b1;
                end
            end
            DELAY: begin
                if (dly_cnt == DLY_W'(LOGOUT_DELAY - 1)) state_d = INACTIVE;
            end
            default: state_d = INACTIVE;
        endcase
    end

    // Registered pulses, gated buttons, lives, streak, delay count and best score.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_reconfig <= 1'b0;
            ts_enable   <= 1'b0;
            psub_b_out  <= 1'b0;
            seq_b_out   <= 1'b0;
            miss        <= 1'b0;
            dead        <= 1'b0;
            checkscore  <= 1'b0;
            logout      <= 1'b0;
            logout_prev <= 1'b0;
            lives_left  <= 4'd0;
            streak      <= 4'd0;
            dly_cnt     <= '0;
            best_score  <= '0;
        end else begin
            ts_reconfig <= reconf;
            ts_enable   <= (state_d == PLAY);
            psub_b_out  <= (state_q == PLAY) && (state_d == PLAY) && psub_b_in;
            seq_b_out   <= (state_q == PLAY) && (state_d == PLAY) && seq_b_in;
            miss        <= miss_d;
            dead        <= dead_d;
            checkscore  <= over_d;
            logout      <= logout_d;
            logout_prev <= logout;

            if (reconf)      lives_left <= 4'(LIVES);
            else if (miss_d) lives_left <= lives_left - 4'd1;
            else if (dead_d) lives_left <= 4'd0;

            if (reconf || miss_d) streak <= 4'd0;
            else if (level_up)    streak <= 4'd0;
            else if (hit)         streak <= streak + 4'd1;

            if (state_q == DELAY) dly_cnt <= dly_cnt + DLY_W'(1);
            else                  dly_cnt <= '0;

            if (state_q == INACTIVE)                best_score <= '0;
            else if (over_d && (score > best_score)) best_score <= score;
        end
    end

    sat_counter #(.WIDTH(SCORE_W), .MAX(SCORE_MAX)) u_score (
        .clk      (clk),
        .rst      (rst),
        .clear    (reconf),
        .inc      (hit),
        .load     (1'b0),
        .load_val ('0),
        .count    (score)
    );

    sat_counter #(.WIDTH(LEVEL_W), .MAX(MAX_LEVEL)) u_level (
        .clk      (clk),
        .rst      (rst),
        .clear    (reconf || over_d || logout_d),
        .inc      (level_up),
        .load     (start),
        .load_val (LEVEL_W'(1)),
        .count    (currentlevel)
    );

endmodule
